data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU's memory-stage data interface. It decodes each access and
//  services it from one of two places: a word-addressed data RAM, or a small
//  memory-mapped I/O page (LED, cycle counter, store counter, countdown timer).
//  It sits beside the mips core in the SoC top. Outputs: readdataM, and board/interrupt signals.
// PARAMETERS
//  RAM_AW     10            RAM word-address width; RAM holds 2**RAM_AW 32-bit words
//  MMIO_BASE  32'hFFFF_0000 base of the MMIO page (address bits [31:5] decoded)
//  LED_W      16            width of LED register
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  memwriteM   in   1      store strobe from CPU memory stage
//  aluoutM     in   32     byte address of the access
//  writedataM  in   32     store data
//  readdataM   out  32     load data, combinational from aluoutM
//  led         out  LED_W  LED register
//  timer_irq   out  1      high while timer is in EXPIRED
//  addr_err    out  1      sticky: misaligned or unmapped access seen
// BEHAVIOUR
//  Interface: one clock domain (clk); reset is asynchronous and active-high (rst).
//  Address decode:
//   - RAM: aluoutM[31:RAM_AW+2]==0; word index = aluoutM[RAM_AW+1:2].
//   - MMIO: aluoutM[31:5]==MMIO_BASE[31:5].
//   - Anything else is unmapped.
//   - Misaligned means aluoutM[1:0]!=0. Misaligned or unmapped: read 0, store dropped, addr_err<=1.
//  Reads: combinational, zero latency (CPU samples readdataM in the same cycle).
//   - A read of the word being stored in the same cycle returns the OLD value.
//  Stores: committed on the rising clk edge while memwriteM=1. The address is not qualified by any other signal.
//  MMIO map (offsets from MMIO_BASE):
//   - 0x00 LED    R/W  bits [LED_W-1:0]; upper read bits 0.
//   - 0x04 CYCLE  RO   32-bit free-running, +1 every cycle, wraps FFFF_FFFF->0. Stores ignored, no error.
//   - 0x08 STCNT  R/W  +1 per committed RAM store, wraps. Any MMIO store here clears it to 0.
//                      A clear takes priority over a same-cycle increment (impossible by construction; still required).
//   - 0x0C TIMER  R/W  read = remaining count; store = load value N.
//   - 0x10 TACK   WO   any store acknowledges the timer; reads 0.
//   - 0x14-0x1C   reserved: read 0, stores ignored, no error.
//  Timer FSM, states IDLE / COUNT / EXPIRED:
//   - Any state: store N to TIMER. N==0 -> IDLE, count=0. N!=0 -> COUNT, count=N.
//     A reload wins over decrement, expiry and TACK.
//   - COUNT: count-=1 each cycle. When count==1, next state is EXPIRED with count=0.
//     So timer_irq rises exactly N cycles after the store edge.
//   - EXPIRED: timer_irq=1 and holds until a TACK store (-> IDLE) or a TIMER reload.
//   - IDLE: timer_irq=0; a TACK store has no effect.
//  Reset values: led=0, CYCLE=0, STCNT=0, timer IDLE with count=0, timer_irq=0, addr_err=0.
//   - RAM contents are NOT reset.
//   - readdataM follows the address combinationally (CYCLE reads 0 during reset).
//   - Reset asserted mid-count aborts the timer immediately; no irq.
//  addr_err clears only on reset.
// TESTING
//  1 Store 32'hDEADBEEF at 0x40, then load 0x40 -> readdataM=DEADBEEF. In the store cycle itself,
//    readdataM shows the prior word. STCNT reads 1.
//  2 Store 0x0000_ABCD at LED (FFFF0000) -> led=16'hABCD, and a load returns 0000ABCD.
//    Store to CYCLE -> CYCLE is unchanged and keeps counting.
//  3 Store 5 to TIMER -> timer_irq=0 for 4 edges, =1 after the 5th edge, and stays 1.
//    Then a TACK store -> timer_irq=0 next cycle, and TIMER reads 0.
//  4 Timer at count 2, then store 10 to TIMER -> count=10 (reload wins). Irq 10 cycles later.
//    Assert rst mid-count -> irq never fires.
//  5 Load 0x41 (misaligned), and store to 0x8000_0000 (unmapped) -> readdataM=0, RAM/STCNT unchanged,
//    addr_err=1 until rst.
//  6 Run CYCLE from reset for 2**32 cycles (or force to FFFF_FFFE) -> wraps to 0.
//    STCNT wrap and clear-on-write verified likewise.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Memory-stage data bus between the CPU (master) and the data-side responder (slave).
//   memwriteM  : store strobe, address is never qualified by anything else
//   aluoutM    : byte address of the access
//   writedataM : store data
//   readdataM  : load data, returned combinationally in the same cycle
interface data_mem_responder_if;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;

  modport master (output memwriteM, output aluoutM, output writedataM, input readdataM);
  modport slave  (input memwriteM, input aluoutM, input writedataM, output readdataM);
endinterface

// File: rtl/data_mem_responder.sv
// Data-side responder for the CPU memory stage: a word-addressed data RAM plus a
// small MMIO page (LED, free-running cycle counter, RAM-store counter, countdown timer).
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : memory-stage data bus (slave side)
//   led        : LED register
//   timer_irq  : high while the countdown timer sits in EXPIRED
//   addr_err   : sticky flag, a misaligned or unmapped address was presented
//
// Timer FSM
//   state     | meaning
//   T_IDLE    | disarmed, count=0, no irq
//   T_COUNT   | counting down once per cycle from the loaded value
//   T_EXPIRED | count reached zero, timer_irq held until TACK or reload
module data_mem_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_responder_if.slave bus,
  output logic [LED_W-1:0] led,
  output logic             timer_irq,
  output logic             addr_err
);

  localparam int RAM_WORDS = 2**RAM_AW;

  typedef enum logic [1:0] {T_IDLE, T_COUNT, T_EXPIRED} tmr_state_e;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        mmio_off;
  logic              is_ram, is_mmio, misaligned, acc_bad;
  logic              st_ok, st_ram, st_mmio;
  logic              st_led, st_stcnt, st_timer, st_tack;

  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       stcnt_q, stcnt_d;
  logic [31:0]       tcount_q, tcount_d;
  tmr_state_e        tstate_q, tstate_d;
  logic              addr_err_q, addr_err_d;

  // Decode
  assign is_ram     = (bus.aluoutM[31:RAM_AW+2] == '0);
  assign is_mmio    = (bus.aluoutM[31:5] == MMIO_BASE[31:5]);
  assign misaligned = |bus.aluoutM[1:0];
  assign acc_bad    = misaligned | ~(is_ram | is_mmio);
  assign ram_idx    = bus.aluoutM[RAM_AW+1:2];
  assign mmio_off   = bus.aluoutM[4:2];

  assign st_ok    = bus.memwriteM & ~acc_bad;
  assign st_ram   = st_ok & is_ram;
  assign st_mmio  = st_ok & is_mmio;
  assign st_led   = st_mmio & (mmio_off == 3'd0);
  assign st_stcnt = st_mmio & (mmio_off == 3'd2);
  assign st_timer = st_mmio & (mmio_off == 3'd3);
  assign st_tack  = st_mmio & (mmio_off == 3'd4);

  // Combinational read; a same-cycle store has not landed yet, so the old word is returned.
  always_comb begin
    bus.readdataM = '0;
    if (!acc_bad) begin
      if (is_ram) begin
        bus.readdataM = mem_q[ram_idx];
      end else begin
        case (mmio_off)
          3'd0:    bus.readdataM[LED_W-1:0] = led_q;
          3'd1:    bus.readdataM = cycle_q;
          3'd2:    bus.readdataM = stcnt_q;
          3'd3:    bus.readdataM = tcount_q;
          default: bus.readdataM = '0;
        endcase
      end
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (st_ram) mem_q[ram_idx] <= bus.writedataM;
  end

  always_comb begin
    led_d      = st_led ? bus.writedataM[LED_W-1:0] : led_q;
    cycle_d    = cycle_q + 32'd1;
    addr_err_d = addr_err_q | acc_bad;
    // Clear outranks increment even though both cannot target the same address at once.
    if (st_stcnt)    stcnt_d = '0;
    else if (st_ram) stcnt_d = stcnt_q + 32'd1;
    else             stcnt_d = stcnt_q;
  end

  // Timer next state: a reload outranks decrement, expiry and TACK.
  always_comb begin
    tstate_d = tstate_q;
    tcount_d = tcount_q;
    if (st_timer) begin
      tcount_d = bus.writedataM;
      tstate_d = (bus.writedataM == '0) ? T_IDLE : T_COUNT;
    end else begin
      case (tstate_q)
        T_COUNT: begin
          if (tcount_q == 32'd1) begin
            tstate_d = T_EXPIRED;
            tcount_d = '0;
          end else begin
            tcount_d = tcount_q - 32'd1;
          end
        end
        T_EXPIRED: if (st_tack) tstate_d = T_IDLE;
        T_IDLE:    tstate_d = T_IDLE;
        default: begin
          tstate_d = T_IDLE;
          tcount_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      cycle_q    <= '0;
      stcnt_q    <= '0;
      tcount_q   <= '0;
      tstate_q   <= T_IDLE;
      addr_err_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      cycle_q    <= cycle_d;
      stcnt_q    <= stcnt_d;
      tcount_q   <= tcount_d;
      tstate_q   <= tstate_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign led       = led_q;
  assign timer_irq = (tstate_q == T_EXPIRED);
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] led;
  logic        timer_irq;
  logic        addr_err;

  data_mem_responder_if bus_if();

  data_mem_responder #(.RAM_AW(10), .MMIO_BASE(BASE), .LED_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .led(led), .timer_irq(timer_irq), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: state kept as plain values, timer as "value loaded" and "cycles elapsed".
  logic [31:0] m_mem [1024];
  bit          m_vld [1024];
  logic [15:0] m_led;
  logic [31:0] m_cycle, m_stcnt, m_tn, m_tage;
  bit          m_tact, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == BASE;
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || !(is_ram(a) || is_mmio(a));
  endfunction

  function automatic bit m_irq();
    return m_tact && (m_tage >= m_tn);
  endfunction

  function automatic logic [31:0] m_trem();
    return m_tact ? (m_tn - m_tage) : 32'h0;
  endfunction

  task automatic exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = 32'h0;
    if (is_bad(a)) v = 32'h0;
    else if (is_ram(a)) begin
      v = m_mem[a[11:2]];
      known = m_vld[a[11:2]];
    end else begin
      case (a - BASE)
        32'h0:   v = {16'h0, m_led};
        32'h4:   v = m_cycle;
        32'h8:   v = m_stcnt;
        32'hC:   v = m_trem();
        default: v = 32'h0;
      endcase
    end
  endtask

  task automatic model_reset();
    m_led = '0; m_cycle = '0; m_stcnt = '0;
    m_tn = '0; m_tage = '0; m_tact = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_update(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit bad, expired, reload, acked;
    bad = is_bad(a);
    expired = m_irq();
    reload = 1'b0;
    acked = 1'b0;
    if (bad) m_err = 1'b1;
    if (we && !bad) begin
      if (is_ram(a)) begin
        m_mem[a[11:2]] = d;
        m_vld[a[11:2]] = 1'b1;
        m_stcnt = m_stcnt + 32'd1;
      end else begin
        case (a - BASE)
          32'h0:  m_led = d[15:0];
          32'h8:  m_stcnt = '0;
          32'hC:  begin m_tn = d; m_tage = '0; m_tact = (d != 0); reload = 1'b1; end
          32'h10: if (expired) begin m_tact = 1'b0; acked = 1'b1; end
          default: ;
        endcase
      end
    end
    if (!reload && !acked && m_tact && m_tage < m_tn) m_tage = m_tage + 32'd1;
    m_cycle = m_cycle + 32'd1;
  endtask

  // One bus cycle: drive at negedge, check the combinational read and outputs, let the edge commit.
  task automatic do_op(input bit we, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] ev;
    bit known;
    @(negedge clk);
    bus_if.memwriteM = we;
    bus_if.aluoutM = a;
    bus_if.writedataM = d;
    #1;
    exp_read(a, ev, known);
    rd = bus_if.readdataM;
    if (known) chk("rdata", rd, ev);
    chk("led", {16'h0, led}, {16'h0, m_led});
    chk("irq", {31'h0, timer_irq}, {31'h0, m_irq()});
    chk("addr_err", {31'h0, addr_err}, {31'h0, m_err});
    @(posedge clk);
    model_update(we, a, d);
    #1;
    bus_if.memwriteM = 1'b0;
    bus_if.aluoutM = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.memwriteM = 1'b0;
    bus_if.aluoutM = BASE + 32'h4;
    #1;
    chk("rst_cycle_rd", bus_if.readdataM, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_err", {31'h0, addr_err}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus_if.aluoutM = 32'h0;
    @(posedge clk);
    model_update(1'b0, 32'h0, 32'h0);
    #1;
  endtask

  initial begin
    logic [31:0] rd, s0, a, d;
    int r;
    rst = 1'b1;
    bus_if.memwriteM = 1'b0;
    bus_if.aluoutM = 32'h0;
    bus_if.writedataM = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);

    // Fill words 0..31 so every later RAM read has a known value.
    apply_reset();
    for (int i = 0; i < 32; i++) do_op(1'b1, i * 4, $urandom, rd);
    apply_reset();

    // Store then load; the store cycle returns the prior word.
    do_op(1'b1, 32'h40, 32'hDEAD_BEEF, rd);
    do_op(1'b0, 32'h40, 32'h0, rd);
    chk("t1_load", rd, 32'hDEAD_BEEF);
    do_op(1'b0, BASE + 32'h8, 32'h0, rd);
    chk("t1_stcnt", rd, 32'h1);

    // LED and a store to the read-only cycle counter.
    do_op(1'b1, BASE, 32'h0000_ABCD, rd);
    chk("t2_led", {16'h0, led}, 32'h0000_ABCD);
    do_op(1'b0, BASE, 32'h0, rd);
    chk("t2_led_rd", rd, 32'h0000_ABCD);
    do_op(1'b0, BASE + 32'h4, 32'h0, s0);
    do_op(1'b1, BASE + 32'h4, 32'h1234_5678, rd);
    do_op(1'b0, BASE + 32'h4, 32'h0, rd);
    chk("t2_cycle_runs", rd, s0 + 32'd2);

    // Timer of 5, then acknowledge.
    do_op(1'b1, BASE + 32'hC, 32'd5, rd);
    repeat (4) do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t3_irq_lo", {31'h0, timer_irq}, 32'h0);
    do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t3_irq_hi", {31'h0, timer_irq}, 32'h1);
    repeat (3) do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    do_op(1'b1, BASE + 32'h10, 32'h0, rd);
    chk("t3_irq_ack", {31'h0, timer_irq}, 32'h0);
    do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t3_timer_rd", rd, 32'h0);

    // Reload mid-count, then reset mid-count.
    do_op(1'b1, BASE + 32'hC, 32'd5, rd);
    repeat (3) do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t4_cnt2", rd, 32'd3);
    do_op(1'b1, BASE + 32'hC, 32'd10, rd);
    do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t4_reload", rd, 32'd10);
    repeat (9) do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t4_irq_10", {31'h0, timer_irq}, 32'h1);
    do_op(1'b1, BASE + 32'hC, 32'd8, rd);
    repeat (3) do_op(1'b0, BASE, 32'h0, rd);
    apply_reset();
    repeat (12) do_op(1'b0, BASE + 32'hC, 32'h0, rd);
    chk("t4_no_irq", {31'h0, timer_irq}, 32'h0);

    // Misaligned and unmapped accesses.
    do_op(1'b0, BASE + 32'h8, 32'h0, s0);
    do_op(1'b0, 32'h41, 32'h0, rd);
    chk("t5_mis_rd", rd, 32'h0);
    chk("t5_err", {31'h0, addr_err}, 32'h1);
    do_op(1'b1, 32'h8000_0000, 32'h5555_5555, rd);
    do_op(1'b1, 32'h0000_0042, 32'h6666_6666, rd);
    do_op(1'b0, 32'h40, 32'h0, rd);
    chk("t5_ram_kept", rd, 32'hDEAD_BEEF);
    do_op(1'b0, BASE + 32'h8, 32'h0, rd);
    chk("t5_stcnt_kept", rd, s0);
    do_op(1'b1, BASE + 32'h18, 32'h7, rd);
    do_op(1'b0, BASE + 32'h14, 32'h0, rd);
    apply_reset();
    chk("t5_err_clr", {31'h0, addr_err}, 32'h0);

    // Counter wraps, forced near the top.
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFE;
    repeat (3) do_op(1'b0, BASE + 32'h4, 32'h0, rd);
    chk("t6_cycle_wrap", rd, 32'h0);
    force dut.stcnt_q = 32'hFFFF_FFFF;
    #1 release dut.stcnt_q;
    m_stcnt = 32'hFFFF_FFFF;
    do_op(1'b1, 32'h10, 32'h1357_9BDF, rd);
    do_op(1'b0, BASE + 32'h8, 32'h0, rd);
    chk("t6_stcnt_wrap", rd, 32'h0);
    repeat (3) do_op(1'b1, 32'h14, $urandom, rd);
    do_op(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, rd);
    do_op(1'b0, BASE + 32'h8, 32'h0, rd);
    chk("t6_stcnt_clr", rd, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) apply_reset();
      r = $urandom_range(0, 39);
      if (r < 20)      a = $urandom_range(0, 31) * 4;
      else if (r < 37) a = BASE + $urandom_range(0, 7) * 4;
      else if (r < 38) a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
      else             a = 32'h8000_0000 + $urandom_range(0, 255) * 4;
      d = (a == BASE + 32'hC) ? $urandom_range(0, 12) : $urandom;
      do_op($urandom_range(0, 2) == 0, a, d, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
